// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: framed multi-byte SPI mode-0 master.
// One START with a byte count opens a CS-low frame. Bytes arrive over a
// valid/ready handshake, are shifted out on MOSI, and each received MISO
// byte comes back with a one-cycle RX_VALID strobe.
//
// Handshake: a byte transfers on a clock edge where o_tx_ready and
// i_tx_valid are both high. o_tx_ready is high only in LOAD, and it does
// not depend on i_tx_valid. The host may hold i_tx_valid low for any
// length of time; S_CLK stays low while it waits.
//
// Build option: define SPI_TXN_SEQUENCER_LSB_FIRST_EN for LSB-first bit
// order. The default build is MSB first. Timing is the same in both builds.
//
// o_state exposes the FSM state for debug.
module spi_txn_sequencer #(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic       i_clk,
   input  logic       i_clr,
   input  logic       i_start,
   input  logic [3:0] i_len,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_cs,
   output logic       o_s_clk,
   output logic       o_mosi,
   input  logic       i_miso,
   output logic [2:0] o_state
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

   logic [2:0] r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_div;
   logic [4:0] r_rem;
   logic [2:0] r_bit;
   logic [7:0] r_tx_sh;
   logic [7:0] r_rx_sh;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_done;
   logic       r_busy;
   logic       r_cs;
   logic       r_sclk;
   logic       r_mosi;
   logic       r_tx_ready;

   logic       w_tick;
   logic       w_hs;
   logic       w_first_bit;
   logic       w_next_bit;
   logic [7:0] w_tx_next;
   logic [7:0] w_rx_next;

   assign w_tick = (r_div == DIV_LAST);
   assign w_hs   = i_tx_valid & r_tx_ready;

`ifdef SPI_TXN_SEQUENCER_LSB_FIRST_EN
   // LSB first: shift right, so the first received bit ends up in bit 0.
   assign w_first_bit = i_tx_data[0];
   assign w_next_bit  = r_tx_sh[1];
   assign w_tx_next   = {1'b0, r_tx_sh[7:1]};
   assign w_rx_next   = {i_miso, r_rx_sh[7:1]};
`else
   // MSB first: shift left, so the first received bit ends up in bit 7.
   assign w_first_bit = i_tx_data[7];
   assign w_next_bit  = r_tx_sh[6];
   assign w_tx_next   = {r_tx_sh[6:0], 1'b0};
   assign w_rx_next   = {r_rx_sh[6:0], i_miso};
`endif

   // Transaction FSM, S_CLK divider, shift registers and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_div      <= 8'd0;
         r_rem      <= 5'd0;
         r_bit      <= 3'd0;
         r_tx_sh    <= 8'h00;
         r_rx_sh    <= 8'h00;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_cs       <= 1'b1;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_tx_ready <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_rem   <= (i_len == 4'd0) ? 5'd16 : {1'b0, i_len};
                  r_cs    <= 1'b0;
                  r_cnt   <= 8'd0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_tx_ready <= 1'b1;
                  r_state    <= ST_LOAD;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_LOAD: begin
               if (w_hs) begin
                  r_tx_sh    <= i_tx_data;
                  r_mosi     <= w_first_bit;
                  r_div      <= 8'd0;
                  r_bit      <= 3'd0;
                  r_tx_ready <= 1'b0;
                  r_state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_tick) begin
                  r_div  <= 8'd0;
                  r_sclk <= ~r_sclk;
                  if (!r_sclk) begin
                     // Rising edge: capture MISO.
                     r_rx_sh <= w_rx_next;
                  end else begin
                     // Falling edge: present the next MOSI bit.
                     r_tx_sh <= w_tx_next;
                     r_mosi  <= w_next_bit;
                     r_bit   <= r_bit + 3'd1;
                     if (r_bit == 3'd7) begin
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_rem      <= r_rem - 5'd1;
                        if (r_rem == 5'd1) begin
                           r_cnt   <= 8'd0;
                           r_state <= ST_HOLD;
                        end else begin
                           r_tx_ready <= 1'b1;
                           r_state    <= ST_LOAD;
                        end
                     end
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            ST_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cs    <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_tx_ready = r_tx_ready;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_cs       = r_cs;
   assign o_s_clk    = r_sclk;
   assign o_mosi     = r_mosi;
   assign o_state    = r_state;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with MISO looped back to MOSI.
module tb_spi_txn_sequencer;

   localparam int D  = 2;
   localparam int SU = 2;
   localparam int HO = 2;

`ifdef SPI_TXN_SEQUENCER_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic       clk;
   logic       clr;
   logic       start;
   logic [3:0] len;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic       cs;
   logic       s_clk;
   logic       mosi;
   logic       miso;
   logic [2:0] state;

   assign miso = mosi;

   spi_txn_sequencer #(.CLK_DIV(D), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
      .i_clk(clk), .i_clr(clr), .i_start(start), .i_len(len),
      .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
      .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy),
      .o_done(done), .o_cs(cs), .o_s_clk(s_clk), .o_mosi(mosi),
      .i_miso(miso), .o_state(state)
   );

   // ---------------- clock / reset ----------------
   int cyc = 0;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] bitrev(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [7:0] exp_q[$];
   int         n_rise = 0;
   int         n_rxv = 0;
   int         n_done = 0;
   int         n_bad_cs = 0;
   int         last_rxv_cyc = 0;
   int         done_cyc = 0;
   logic [7:0] mosi_bits = 8'h00;
   logic       prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (s_clk === 1'b1 && prev_sclk === 1'b0) begin
         n_rise++;
         mosi_bits = {mosi_bits[6:0], mosi};
      end
      prev_sclk = s_clk;
      if (cs === 1'b1 && busy === 1'b1) n_bad_cs++;
      if (rx_valid === 1'b1) begin
         n_rxv++;
         last_rxv_cyc = cyc;
         if (exp_q.size() == 0) check_eq("rx_unexpected", 32'd1, 32'd0);
         else check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc;
         check_eq("cs_at_done", {31'd0, cs}, 32'd1);
         check_eq("busy_at_done", {31'd0, busy}, 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   int hs_cyc = 0;

   task automatic do_start(input logic [3:0] l);
      len   = l;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Returns in the first cycle after the handshake edge.
   task automatic send_byte(input logic [7:0] d);
      int n;
      n        = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) check_eq("ready_timeout", 32'd0, 32'd1);
      step();
      tx_valid = 1'b0;
      hs_cyc   = cyc;
   endtask

   task automatic wait_done(input int limit);
      int base;
      int n;
      base = n_done;
      n    = 0;
      while (n_done == base && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_cs"}, {31'd0, cs}, 32'd1);
      check_eq({tag, "_sclk"}, {31'd0, s_clk}, 32'd0);
      check_eq({tag, "_mosi"}, {31'd0, mosi}, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
      check_eq({tag, "_rxdata"}, {24'd0, rx_data}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         b_rise;
      int         b_rxv;
      int         b_done;
      int         k;
      logic       bad;
      logic [7:0] d;

      clr = 1'b1; start = 1'b0; len = 4'd0; tx_data = 8'h00; tx_valid = 1'b0;
      step();
      step();
      clr = 1'b0;
      check_idle("reset");
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_rxv", {31'd0, rx_valid}, 32'd0);

      // Single byte A5 with loopback.
      b_rise = n_rise; b_rxv = n_rxv; b_done = n_done;
      do_start(4'd1);
      check_eq("start_cs_low", {31'd0, cs}, 32'd0);
      check_eq("start_busy", {31'd0, busy}, 32'd1);
      step();
      check_eq("setup_ready_early", {31'd0, tx_ready}, 32'd0);
      step();
      check_eq("setup_ready", {31'd0, tx_ready}, 32'd1);
      exp_q.push_back(8'hA5);
      send_byte(8'hA5);
      k = 0;
      while (s_clk !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      check_eq("first_rise_lat", k, D);
      wait_done(200);
      check_eq("single_rises", n_rise - b_rise, 8);
      check_eq("single_mosi", {24'd0, mosi_bits}, {24'd0, LSB ? bitrev(8'hA5) : 8'hA5});
      check_eq("single_rxv", n_rxv - b_rxv, 1);
      check_eq("single_rxv_lat", last_rxv_cyc - hs_cyc, 16 * D);
      check_eq("single_done", n_done - b_done, 1);
      check_eq("single_hold_lat", done_cyc - last_rxv_cyc, HO);
      step();
      check_eq("single_done_strobe", {31'd0, done}, 32'd0);

      // Burst of three with a 5-cycle stall before byte 2.
      b_rise = n_rise; b_rxv = n_rxv; b_done = n_done;
      do_start(4'd3);
      exp_q.push_back(8'h01);
      send_byte(8'h01);
      k = 0;
      while (tx_ready !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (s_clk !== 1'b0 || cs !== 1'b0 || tx_ready !== 1'b1) bad = 1'b1;
         step();
      end
      check_eq("stall_bus", {31'd0, bad}, 32'd0);
      exp_q.push_back(8'h80);
      send_byte(8'h80);
      exp_q.push_back(8'hFF);
      send_byte(8'hFF);
      wait_done(200);
      check_eq("burst_rises", n_rise - b_rise, 24);
      check_eq("burst_rxv", n_rxv - b_rxv, 3);
      check_eq("burst_done", n_done - b_done, 1);

      // LEN=0 means 16 bytes, back-to-back.
      b_rise = n_rise; b_rxv = n_rxv; b_done = n_done;
      do_start(4'd0);
      for (int i = 0; i < 16; i++) begin
         d = 8'(i * 37 + 5);
         exp_q.push_back(d);
         send_byte(d);
      end
      wait_done(200);
      check_eq("len0_rises", n_rise - b_rise, 128);
      check_eq("len0_rxv", n_rxv - b_rxv, 16);
      check_eq("len0_done", n_done - b_done, 1);

      // START while busy is ignored; CLR at the 4th rise aborts cleanly.
      b_rise = n_rise; b_rxv = n_rxv; b_done = n_done;
      do_start(4'd1);
      send_byte(8'h3C);
      start = 1'b1;
      len   = 4'd5;
      step();
      start = 1'b0;
      check_eq("busy_start_state", {29'd0, state}, 32'd3);
      check_eq("busy_start_cs", {31'd0, cs}, 32'd0);
      k = 0;
      while (n_rise - b_rise < 4 && k < 100) begin
         step();
         k++;
      end
      check_eq("abort_reach_rise4", n_rise - b_rise, 4);
      clr = 1'b1;
      step();
      check_idle("clr1");
      step();
      check_idle("clr2");
      clr = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_eq("abort_no_done", n_done - b_done, 0);
      check_eq("abort_no_rxv", n_rxv - b_rxv, 0);
      check_eq("abort_idle_state", {29'd0, state}, 32'd0);
      b_rxv = n_rxv; b_done = n_done;
      do_start(4'd1);
      exp_q.push_back(8'hC3);
      send_byte(8'hC3);
      wait_done(200);
      check_eq("after_clr_rxv", n_rxv - b_rxv, 1);
      check_eq("after_clr_done", n_done - b_done, 1);

      // Bit-order case: 8'h01 looped back.
      b_rxv = n_rxv;
      do_start(4'd1);
      exp_q.push_back(8'h01);
      send_byte(8'h01);
      wait_done(200);
      check_eq("order_mosi", {24'd0, mosi_bits}, {24'd0, LSB ? 8'h80 : 8'h01});
      check_eq("order_rxv", n_rxv - b_rxv, 1);

      step();
      check_eq("sb_empty", exp_q.size(), 0);
      check_eq("cs_high_while_busy", n_bad_cs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Sequences multi-byte SPI master transactions for the SPI interface. A host issues one START with a byte count and streams bytes over a valid/ready handshake. The block then drives CS, divides CLK down to S_CLK, shifts MOSI in SPI mode 0 and returns each MISO byte with a one-cycle strobe. It sits between the host-side control/status logic and the serial pins, replacing free-running S_CLK gating with a counted, framed transfer.

## Interface
- CLK_DIV, 2: CLK cycles per S_CLK half-period; legal values are 1 to 255.
- CS_SETUP, 2: CLK cycles from CS falling to the first LOAD; legal values are 1 to 255.
- CS_HOLD, 2: CLK cycles from the last S_CLK falling edge to CS rising; legal values are 1 to 255.
- CLK  input  1  system clock; single clock domain.
- CLR  input  1  reset, synchronous, active-high.
- START  input  1  begin a transaction; sampled only in IDLE.
- LEN  input  4  byte count, latched on START; 0 means 16.
- TX_DATA  input  8  next byte to send.
- TX_VALID  input  1  TX_DATA is valid.
- TX_READY  output  1  block accepts TX_DATA this cycle.
- RX_DATA  output  8  last received byte; holds until the next byte completes.
- RX_VALID  output  1  one-cycle strobe when RX_DATA updates.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle strobe when a transaction ends.
- CS  output  1  chip select, active-low.
- S_CLK  output  1  serial clock; idles low (mode 0).
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in; treated as synchronous to CLK.

## Operation
- States: IDLE, SETUP, LOAD, SHIFT, HOLD.
- IDLE:
  - On START, latch LEN into rem (0 becomes 16), drive CS low, clear the counter, go to SETUP.
  - START in any other state is ignored.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD:
  - TX_READY=1; S_CLK stays low; CS stays low.
  - On TX_VALID&TX_READY: load the shift register, drive MOSI with the first bit, clear the divider, go to SHIFT.
  - TX_VALID low stalls indefinitely; the stall is legal on the bus because S_CLK is low.
- SHIFT:
  - The divider counts 0..CLK_DIV-1; at terminal count S_CLK toggles.
  - On a rising toggle, sample MISO into the receive register.
  - On a falling toggle, advance MOSI to the next bit.
  - On the 8th falling toggle:
    - RX_DATA takes the receive register and RX_VALID pulses.
    - rem decrements.
    - If rem becomes 0, go to HOLD; otherwise go to LOAD.
- HOLD: count CS_HOLD cycles, then drive CS high, pulse DONE, go to IDLE.
- Bit order is MSB first by default.
- Counters: rem is 5 bits; bit count is 3 bits and wraps 7→0 at each byte boundary.
- CLR in any state takes effect at the next CLK edge:
  - State → IDLE.
  - CS=1, S_CLK=0, MOSI=0, TX_READY=0, RX_VALID=0, DONE=0, BUSY=0, RX_DATA=8'h00.
  - No DONE is produced for an aborted transaction; the partial byte is discarded.

## Timing
- All outputs are registered.
- START→CS low: 1 cycle.
- CS low→TX_READY: CS_SETUP cycles.
- Handshake cycle→first S_CLK rise: CLK_DIV cycles.
- One byte in SHIFT: exactly 16·CLK_DIV cycles; RX_VALID is high in the cycle after the 8th falling edge.
- Next LOAD begins the same cycle RX_VALID is high, so back-to-back TX_VALID gives a 1-cycle gap between bytes.
- Last falling edge→CS high: CS_HOLD cycles; DONE is high in the same cycle as CS rises; BUSY drops that cycle.
- START asserted in the DONE cycle is accepted on the next cycle (IDLE is entered first).
- MOSI changes only on the handshake cycle or on falling toggles; it is stable across every S_CLK rise.

## Configuration
- Macro: SPI_TXN_SEQUENCER_LSB_FIRST_EN.
- Defined: bit order is LSB first. MOSI carries TX_DATA[0] first; MISO fills RX_DATA from bit 7 downward, so the first bit received lands in RX_DATA[0].
- Undefined: MSB first. MOSI carries TX_DATA[7] first; the first bit received lands in RX_DATA[7].
- Timing and handshake are identical in both builds.

## Test plan
- Reset: hold CLR 2 cycles mid-run → CS=1, S_CLK=0, MOSI=0, BUSY=0, RX_DATA=8'h00, no DONE.
- Single byte, CLK_DIV=2, MISO looped to MOSI, LEN=1, TX_DATA=8'hA5 → 8 S_CLK pulses, MOSI pattern 1010_0101, RX_DATA=8'hA5, RX_VALID exactly once 32 cycles after the handshake, DONE 2 cycles after the last fall.
- Burst LEN=3 (8'h01, 8'h80, 8'hFF) with TX_VALID withheld 5 cycles before byte 2 → S_CLK low and CS low during the stall, 3 RX_VALID strobes, one DONE, CS low throughout.
- LEN=0 → exactly 16 bytes and 128 S_CLK rises before DONE.
- START pulsed while BUSY, and CLR asserted at the 4th rise of byte 1 → extra START ignored; after CLR, idle outputs appear next cycle, then a new START yields a clean 1-byte transfer.
- With SPI_TXN_SEQUENCER_LSB_FIRST_EN defined, TX_DATA=8'h01, loopback → MOSI high only on the first bit, RX_DATA=8'h01.
